gcd_unit: RTL

Iterative subtractive greatest-common-divisor engine for the GCD datapath. It accepts an operand pair over a valid/ready handshake and loads the operand registers through the 2:1 load/feedback multiplexers. It then performs one subtract-and-compare step per clock. The result and the step count are returned over a second valid/ready handshake. It processes one problem at a time: no pipelining and no input buffering.

---
 rtl/gcd_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/gcd_unit.sv
`default_nettype none
// ============================================================================
// Module      : gcd_unit
// Description : Iterative subtractive GCD engine. Accepts one operand pair
//               over a valid/ready handshake, performs one subtract-and-
//               compare step per clock, and returns the result plus the
//               saturating subtraction count over a second handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_unit #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     gcd_out,
    output logic [CNT_WIDTH-1:0] iter_count
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [WIDTH-1:0]     c_OP_ZERO  = '0;

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]     r_res;

    // Handshake flags and result ports are straight decodes of the state
    // and result registers, so they change only on clock edges.
    assign in_ready   = (r_state == c_ST_IDLE);
    assign out_valid  = (r_state == c_ST_DONE);
    assign gcd_out    = r_res;
    assign iter_count = r_cnt;

    // Control FSM and datapath: load, one subtract/compare step per cycle, hold result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // Load multiplexers select the external operands on accept.
                    if (in_valid) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_cnt   <= '0;
                        r_state <= c_ST_CALC;
                    end
                end
                c_ST_CALC: begin
                    if ((r_a == c_OP_ZERO) || (r_b == c_OP_ZERO)) begin
                        // A zero operand leaves the other as the result; 0|0 = 0.
                        r_res   <= r_a | r_b;
                        r_state <= c_ST_DONE;
                    end else if (r_a == r_b) begin
                        r_res   <= r_a;
                        r_state <= c_ST_DONE;
                    end else if (r_a > r_b) begin
                        // Larger operand is always the minuend, so no underflow.
                        r_a   <= r_a - r_b;
                        r_cnt <= (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;
                    end else begin
                        r_b   <= r_b - r_a;
                        r_cnt <= (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_DONE: begin
                    // Result and count hold until the consumer takes them.
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
